ks_note_ctrl: RTL

KS_NOTE_CTRL -- requirements
Module: ks_note_ctrl

---
 rtl/ks_pkg.sv | 38 +++
 rtl/ks_onehot_dec.sv | 19 +
 rtl/ks_note_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ks_pkg.sv
// Shared types, per-note tables and helpers for the Karplus-Strong note controller.
package ks_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConfig,
    StBurst,
    StPlay
  } ks_state_e;

  // Number of entries in the per-note tables and width of a delay-length entry.
  localparam int unsigned TblNotes = 10;
  localparam int unsigned TblLenW  = 10;

  // Sample-rate divider for each note; paired with the delay length below so that
  // sample rate / delay length lands on the note pitch.
  localparam logic [31:0] DIV_FREQ_TBL [TblNotes] = '{
    32'd1042, 32'd1045, 32'd1051, 32'd1053, 32'd1046,
    32'd1048, 32'd1052, 32'd1049, 32'd1050, 32'd1044
  };

  // Delay-line length (samples per period) for each note; zero is never allowed.
  localparam logic [TblLenW-1:0] DELAY_LEN_TBL [TblNotes] = '{
    10'd183, 10'd163, 10'd145, 10'd137, 10'd122,
    10'd109, 10'd97,  10'd91,  10'd82,  10'd73
  };

  // Position of the set bit; OR-ing all set positions is exact when the input is one-hot.
  function automatic int unsigned onehot_to_index(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ks_onehot_dec.sv
// One-hot note request decoder: note index plus an exactly-one-bit-set flag.
module ks_onehot_dec
  import ks_pkg::*;
#(
  parameter int unsigned NUM_NOTES = 10,
  parameter int unsigned IDX_W     = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
  input  logic [NUM_NOTES-1:0] onehot,
  output logic [IDX_W-1:0]     index,
  output logic                 valid
);

  // Decode index; clearing the lowest set bit leaves zero only for a single set bit.
  always_comb begin
    index = IDX_W'(onehot_to_index(32'(onehot)));
    valid = (onehot != '0) && ((onehot & (onehot - NUM_NOTES'(1))) == '0);
  end

endmodule

// File: rtl/ks_note_ctrl.sv
// Karplus-Strong note controller: accepts one-hot note requests, configures the
// divider and delay line, preloads the delay line with a noise burst, then lets the
// averaging feedback ring for the requested number of sample ticks.
module ks_note_ctrl
  import ks_pkg::*;
#(
  parameter int unsigned NUM_NOTES = 10,
  parameter int unsigned LEN_W     = 10,
  parameter int unsigned SUS_W     = 16
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [NUM_NOTES-1:0] sel_nota,
  input  logic                 note_valid,
  output logic                 note_ready,
  input  logic [SUS_W-1:0]     sustain_len,
  input  logic                 sample_tick,
  input  logic [15:0]          noise,
  output logic                 noise_en,
  output logic                 noise_pulse,
  output logic [31:0]          div_freq,
  output logic [LEN_W-1:0]     delay_len,
  output logic                 dl_wr_en,
  output logic [LEN_W-1:0]     dl_wr_addr,
  output logic [15:0]          dl_wr_data,
  output logic                 fb_en,
  output logic                 busy,
  output logic                 err_note
);

  localparam int unsigned IdxW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;

  ks_state_e state_q, state_d;

  logic [IdxW-1:0]  dec_idx;
  logic             dec_valid;
  logic [IdxW-1:0]  note_idx_q;
  logic [SUS_W-1:0] sus_q;
  logic [LEN_W-1:0] addr_q;
  logic [LEN_W-1:0] delay_len_q;
  logic [31:0]      div_freq_q;
  logic             wr_en_q;
  logic [LEN_W-1:0] wr_addr_q;
  logic [15:0]      wr_data_q;
  logic             noise_pulse_q;
  logic             err_q;

  logic             accept;
  logic             accept_ok;
  logic             burst_last;
  logic             play_done;
  logic [31:0]      tbl_div;
  logic [LEN_W-1:0] tbl_len;

  ks_onehot_dec #(
    .NUM_NOTES (NUM_NOTES),
    .IDX_W     (IdxW)
  ) u_dec (
    .onehot (sel_nota),
    .index  (dec_idx),
    .valid  (dec_valid)
  );

  // Handshake qualification and FSM transition conditions.
  always_comb begin
    accept     = note_valid && note_ready;
    accept_ok  = accept && dec_valid;
    burst_last = sample_tick && (addr_q == delay_len_q - LEN_W'(1));
    // A zero sustain leaves PLAY immediately, without waiting for a tick.
    play_done  = (sus_q == '0) || (sample_tick && (sus_q == SUS_W'(1)));
  end

  // Per-note table lookup; out-of-table indices fall back to entry 0.
  always_comb begin
    tbl_div = DIV_FREQ_TBL[0];
    tbl_len = LEN_W'(DELAY_LEN_TBL[0]);
    for (int unsigned i = 0; i < TblNotes; i++) begin
      if (32'(note_idx_q) == i) begin
        tbl_div = DIV_FREQ_TBL[i];
        tbl_len = LEN_W'(DELAY_LEN_TBL[i]);
      end
    end
  end

  // State register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a retrigger in PLAY beats sustain expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept_ok) state_d = StConfig;
      StConfig: state_d = StBurst;
      StBurst:  if (burst_last) state_d = StPlay;
      StPlay: begin
        if (accept_ok) begin
          state_d = StConfig;
        end else if (play_done) begin
          state_d = StIdle;
        end
      end
      default:  state_d = StIdle;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    note_ready = (state_q == StIdle) || (state_q == StPlay);
    busy       = (state_q != StIdle);
    noise_en   = (state_q == StBurst);
    fb_en      = (state_q == StPlay);
  end

  // Datapath: request latching, configuration, burst writes and registered pulses.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      note_idx_q    <= '0;
      sus_q         <= '0;
      addr_q        <= '0;
      delay_len_q   <= '0;
      div_freq_q    <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      noise_pulse_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      wr_en_q       <= 1'b0;
      noise_pulse_q <= 1'b0;
      err_q         <= accept && !dec_valid;

      if (accept_ok) begin
        note_idx_q <= dec_idx;
        sus_q      <= sustain_len;
      end else if ((state_q == StPlay) && sample_tick && (sus_q != '0)) begin
        sus_q <= sus_q - SUS_W'(1);
      end

      if (state_q == StConfig) begin
        div_freq_q  <= tbl_div;
        delay_len_q <= tbl_len;
        addr_q      <= '0;
      end

      if ((state_q == StBurst) && sample_tick) begin
        wr_en_q       <= 1'b1;
        wr_addr_q     <= addr_q;
        wr_data_q     <= noise;
        noise_pulse_q <= 1'b1;
        addr_q        <= addr_q + LEN_W'(1);
      end
    end
  end

  assign div_freq    = div_freq_q;
  assign delay_len   = delay_len_q;
  assign dl_wr_en    = wr_en_q;
  assign dl_wr_addr  = wr_addr_q;
  assign dl_wr_data  = wr_data_q;
  assign noise_pulse = noise_pulse_q;
  assign err_note    = err_q;

endmodule
